reg_share_arbiter: RTL and testbench

Shares one WIDTH-bit output register (the LED/pattern register driven by the blink logic) between N_REQ requesters. Requesters are served round-robin. The winner's pattern is latched into the register and held for a fixed number of prescaled ticks. The grant is then released and the next pending requester is served. The block sits between pattern sources (blinkers, status logic) and the board LED pins.

---
 rtl/reg_share_arbiter_pkg.sv | 23 ++
 rtl/reg_share_arbiter_tick_gen.sv | 30 +++
 rtl/reg_share_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_share_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the LED-register sharing arbiter: FSM encoding and
// an elaboration-time log2 helper used to size index and counter fields.
package reg_share_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_share_arbiter_tick_gen.sv
// Free-running prescaler: counts while enabled and pulses tick for one cycle
// each time the TICK_BITS-wide counter reaches all-ones, then wraps to zero.
module tick_gen
    import reg_share_arbiter_pkg::*;
#(
    parameter int TICK_BITS = 22
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    output logic tick
);

    logic [TICK_BITS-1:0] count;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + TICK_BITS'(1);
        end
    end

    assign tick = &count;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of a shared WIDTH-bit pattern register: latches the
// winner's pattern at grant and holds it for HOLD_TICKS prescaled ticks.
module reg_share_arbiter
    import reg_share_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 4,
    parameter int TICK_BITS  = 22,
    parameter int HOLD_TICKS = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   data_in,
    output logic [N_REQ-1:0]         grant,
    output logic [WIDTH-1:0]         dout,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int HC_W  = clog2(HOLD_TICKS) + 1;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     cur;
    logic [IDX_W-1:0]     win;
    logic [HC_W-1:0]      hold_cnt;
    logic                 tick;
    logic                 start;
    logic                 rel;
    logic [WIDTH-1:0]     slices [N_REQ];

    // First requester strictly after 'last', wrapping; the sum is one bit wider
    // so the explicit modulo also works when N_REQ is not a power of two.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W:0]   idx;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = {1'b0, last} + (IDX_W + 1)'(i);
            if (idx >= (IDX_W + 1)'(N_REQ)) begin
                idx = idx - (IDX_W + 1)'(N_REQ);
            end
            if (!found && r[idx[IDX_W-1:0]]) begin
                pick  = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slices[i] = data_in[i*WIDTH +: WIDTH];
        end
    end

    assign win = rr_pick(req, last_grant);

    tick_gen #(
        .TICK_BITS (TICK_BITS)
    ) u_tick_gen (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .clear  (state != ST_HOLD),
        .tick   (tick)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and a latch cannot form.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!req[cur] || (tick && hold_cnt == HC_W'(HOLD_TICKS - 1))) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        start = (state == ST_IDLE) && (state_next == ST_HOLD);
        rel   = (state == ST_HOLD) && (state_next == ST_IDLE);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            grant      <= '0;
            dout       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hold_cnt   <= '0;
            cur        <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
        end else begin
            done <= 1'b0;
            if (start) begin
                grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                dout     <= slices[win];
                busy     <= 1'b1;
                hold_cnt <= '0;
                cur      <= win;
            end else if (rel) begin
                grant      <= '0;
                busy       <= 1'b0;
                done       <= 1'b1;
                last_grant <= cur;
            end else if (state == ST_HOLD && tick) begin
                hold_cnt <= hold_cnt + HC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter with a cycle-level reference model
// checked every clock, plus hand-computed expectations for each scenario.
module tb_reg_share_arbiter;

    localparam int N_REQ      = 4;
    localparam int WIDTH      = 4;
    localparam int TICK_BITS  = 2;
    localparam int HOLD_TICKS = 2;
    localparam int HOLD_LEN   = HOLD_TICKS * (1 << TICK_BITS);

    logic                   clk_in  = 1'b0;
    logic                   rst_in  = 1'b1;
    logic [N_REQ-1:0]       req     = '0;
    logic [N_REQ*WIDTH-1:0] data_in = '0;
    logic [N_REQ-1:0]       grant;
    logic [WIDTH-1:0]       dout;
    logic                   busy;
    logic                   done;

    int vec_cnt     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model: owner index (-1 when idle), edges elapsed since grant.
    int         m_owner   = -1;
    int         m_last    = N_REQ - 1;
    int         m_elapsed = 0;
    logic [3:0] m_dout    = '0;
    logic       m_done    = 1'b0;
    int         m_order[$];
    logic [3:0] dut_order[$];
    logic [3:0] prev_grant = '0;

    reg_share_arbiter #(
        .N_REQ      (N_REQ),
        .WIDTH      (WIDTH),
        .TICK_BITS  (TICK_BITS),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .req     (req),
        .data_in (data_in),
        .grant   (grant),
        .dout    (dout),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] slice_of(input logic [15:0] d, input int i);
        return d[i*4 +: 4];
    endfunction

    always @(posedge clk_in or posedge rst_in) begin : model
        int w;
        if (rst_in) begin
            m_owner   <= -1;
            m_last    <= N_REQ - 1;
            m_elapsed <= 0;
            m_dout    <= '0;
            m_done    <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_owner < 0) begin
                w = -1;
                for (int k = 1; k <= N_REQ; k++) begin
                    if (w < 0 && req[(m_last + k) % N_REQ]) w = (m_last + k) % N_REQ;
                end
                if (w >= 0) begin
                    m_owner   <= w;
                    m_elapsed <= 0;
                    m_dout    <= slice_of(data_in, w);
                    m_order.push_back(w);
                end
            end else if (!req[m_owner] || m_elapsed + 1 == HOLD_LEN) begin
                m_last  <= m_owner;
                m_owner <= -1;
                m_done  <= 1'b1;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
        end
    end

    always @(posedge clk_in) begin
        #1;
        if (!rst_in && chk_en) begin
            check("cyc_grant", grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("cyc_dout", dout, m_dout);
            check("cyc_busy", busy, m_owner >= 0);
            check("cyc_done", done, m_done);
        end
        if (!rst_in && grant != 0 && prev_grant == 0) dut_order.push_back(grant);
        prev_grant = grant;
    end

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check(name, done, 1);
    endtask

    initial begin
        int         n;
        int         done_acc;
        logic [3:0] rr_exp [5];
        int         rr_idx [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_idx = '{0, 1, 2, 3, 0};

        // Reset then idle.
        repeat (2) @(negedge clk_in);
        check("rst_grant", grant, 0);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_in = 1'b0;
        chk_en = 1'b1;
        done_acc = 0;
        repeat (20) begin
            @(negedge clk_in);
            done_acc += int'(done);
        end
        check("idle_done_pulses", done_acc, 0);
        check("idle_grant", grant, 0);
        check("idle_dout", dout, 0);

        // Round-robin with all four requesting.
        data_in = 16'h8421;
        req     = 4'hF;
        n = 0;
        while (dut_order.size() < 5 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check("rr_grant_count", dut_order.size(), 5);
        wait_done("rr_final_done", 20);
        req = '0;
        if (dut_order.size() >= 5 && m_order.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check("rr_dut_order", dut_order[i], rr_exp[i]);
                check("rr_model_order", m_order[i], rr_idx[i]);
            end
        end
        check("rr_dout_after", dout, 4'b0001);

        // Single grant to requester 1.
        @(negedge clk_in);
        data_in = 16'h00A0;
        req     = 4'b0010;
        @(negedge clk_in);
        check("single_grant", grant, 4'b0010);
        check("single_dout", dout, 4'b1010);
        check("single_busy", busy, 1);
        repeat (7) @(negedge clk_in);
        check("single_still_held", grant, 4'b0010);
        check("single_no_early_done", done, 0);
        @(negedge clk_in);
        check("single_released", grant, 0);
        check("single_done", done, 1);
        check("single_dout_kept", dout, 4'b1010);
        check("single_busy_low", busy, 0);
        req = '0;
        @(negedge clk_in);
        check("single_done_one_cycle", done, 0);

        // Early release of requester 2, then wrap to requester 0.
        data_in = 16'h0005;
        req     = 4'b0100;
        @(negedge clk_in);
        check("early_grant", grant, 4'b0100);
        req = 4'b0111;
        repeat (3) @(negedge clk_in);
        req = 4'b0011;
        @(negedge clk_in);
        check("early_released", grant, 0);
        check("early_done", done, 1);
        @(negedge clk_in);
        check("early_next_wraps", grant, 4'b0001);
        check("early_next_dout", dout, 4'b0101);

        // Data isolation during requester 0's hold.
        req     = 4'b0001;
        data_in = 16'h000F;
        repeat (7) begin
            @(negedge clk_in);
            check("iso_dout", dout, 4'b0101);
        end
        check("iso_grant_held", grant, 4'b0001);
        @(negedge clk_in);
        check("iso_done", done, 1);
        check("iso_dout_after", dout, 4'b0101);
        @(negedge clk_in);
        check("persist_regrant", grant, 4'b0001);
        check("persist_new_dout", dout, 4'b1111);

        // Asynchronous reset in the middle of a hold.
        @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_grant", grant, 0);
        check("arst_dout", dout, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        req     = 4'hF;
        data_in = 16'h8421;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("arst_first_grant", grant, 4'b0001);
        check("arst_first_dout", dout, 4'b0001);
        repeat (20) @(negedge clk_in);
        req = '0;
        repeat (12) @(negedge clk_in);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
